pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the flow-controlled pipeline stage registers:
// FSM state encoding and the EX/MEM and MEM/WB payload widths.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_FULL  = 2'd1;
    localparam state_t ST_SKID  = 2'd2;

    // EX/MEM: RegWrite, ResultSrc, MemWrite, LoadSize | ALUResult, WriteData, PCPlus4, Rd
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 101;

    // MEM/WB: RegWrite, ResultSrc | ALUResult, ReadData, PCPlus4, Rd
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 101;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance counter.
// Counts every cycle inc is high, sticks at all-ones, cleared only by rst.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush (bubble insertion),
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = EXMEM_CTRL_W,
    parameter int DATA_W  = EXMEM_DATA_W,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              stall_inc_s;

    assign out_valid   = (state_q != ST_EMPTY);
    assign out_ctrl    = main_ctrl_q;
    assign out_data    = main_data_q;
    assign in_ready    = (SKID_EN != 0) ? in_ready_q : (out_ready | ~out_valid);
    assign in_xfer_s   = in_valid & in_ready;
    assign out_xfer_s  = out_valid & out_ready;
    assign stall_inc_s = out_valid & ~out_ready;

    // Next-state and payload steering; every path into EMPTY zeroes main ctrl.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
        end else if (SKID_EN != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_valid) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_ready) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end else begin
            if (in_xfer_s) begin
                state_d     = ST_FULL;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (out_xfer_s) begin
                state_d     = ST_EMPTY;
                main_ctrl_d = {CTRL_W{1'b0}};
            end else begin
                state_d = state_q;
            end
        end
        in_ready_d = (state_d != ST_SKID);
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= {CTRL_W{1'b0}};
            main_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid-buffer, combinational-ready and
// 4-bit-counter instances driven by one linear sequence of steps.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 101;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // A: SKID_EN=1, B: SKID_EN=0, C: SKID_EN=1 with CNT_W=4
    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [15:0]   a_stall;
    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_stall;
    logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [CW-1:0] c_in_ctrl, c_out_ctrl;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [3:0]    c_stall;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .stall_cnt(c_stall));

    function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
        return {1'b1, 92'h0, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 8'hFF; a_in_data = mkdata(8'hFF); a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b1; b_in_ctrl = 8'hFF; b_in_data = mkdata(8'hFF); b_out_ready = 1'b1;
        c_flush = 1'b0; c_in_valid = 1'b1; c_in_ctrl = 8'hFF; c_in_data = mkdata(8'hFF); c_out_ready = 1'b1;

        // Reset held two cycles with an entry offered
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_a_valid", a_out_valid, 1'b0);
            chk("rst_a_ctrl",  a_out_ctrl,  8'h00);
            chk("rst_a_data",  a_out_data,  {DW{1'b0}});
            chk("rst_a_stall", a_stall,     16'h0000);
            chk("rst_a_ready", a_in_ready,  1'b1);
            chk("rst_b_valid", b_out_valid, 1'b0);
            chk("rst_b_ctrl",  b_out_ctrl,  8'h00);
            chk("rst_b_ready", b_in_ready,  1'b1);
            chk("rst_c_stall", c_stall,     4'h0);
        end
        rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        tick();
        chk("idle_a_valid", a_out_valid, 1'b0);

        // Stream on A: 01..05 back to back
        for (int i = 1; i <= 5; i++) begin
            a_in_valid = 1'b1; a_in_ctrl = 8'(i); a_in_data = mkdata(8'(i));
            tick();
            chk("strm_a_valid", a_out_valid, 1'b1);
            chk("strm_a_ctrl",  a_out_ctrl,  8'(i));
            chk("strm_a_data",  a_out_data,  mkdata(8'(i)));
            chk("strm_a_ready", a_in_ready,  1'b1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("drain_a_valid", a_out_valid, 1'b0);
        chk("drain_a_ctrl",  a_out_ctrl,  8'h00);
        chk("drain_a_stall", a_stall,     16'h0000);

        // Backpressure on A: A1, B2, C3 with out_ready low for three cycles
        a_in_valid = 1'b1; a_in_ctrl = 8'hA1; a_in_data = mkdata(8'hA1);
        tick();
        chk("bp_a_A1", a_out_ctrl, 8'hA1);
        a_out_ready = 1'b0; a_in_ctrl = 8'hB2; a_in_data = mkdata(8'hB2);
        tick();
        chk("bp_a_hold_A1", a_out_ctrl, 8'hA1);
        chk("bp_a_ready0",  a_in_ready, 1'b0);
        chk("bp_a_stall1",  a_stall,    16'd1);
        a_in_ctrl = 8'hC3; a_in_data = mkdata(8'hC3);
        tick();
        chk("bp_a_stall2", a_stall, 16'd2);
        tick();
        chk("bp_a_stall3", a_stall,    16'd3);
        chk("bp_a_still",  a_out_ctrl, 8'hA1);
        a_out_ready = 1'b1;
        tick();
        chk("bp_a_B2",     a_out_ctrl, 8'hB2);
        chk("bp_a_B2data", a_out_data, mkdata(8'hB2));
        chk("bp_a_ready1", a_in_ready, 1'b1);
        tick();
        chk("bp_a_C3", a_out_ctrl, 8'hC3);
        a_in_valid = 1'b0;
        tick();
        chk("bp_a_empty", a_out_valid, 1'b0);
        chk("bp_a_stall", a_stall,     16'd3);

        // Flush on A while in SKID with an entry offered
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 8'h11; a_in_data = mkdata(8'h11);
        tick();
        a_in_ctrl = 8'h22; a_in_data = mkdata(8'h22);
        tick();
        chk("fl_a_skid_rdy", a_in_ready, 1'b0);
        chk("fl_a_stall4",   a_stall,    16'd4);
        a_in_ctrl = 8'h33; a_in_data = mkdata(8'h33); a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_a_valid", a_out_valid, 1'b0);
        chk("fl_a_ctrl",  a_out_ctrl,  8'h00);
        chk("fl_a_ready", a_in_ready,  1'b1);
        chk("fl_a_data",  a_out_data,  mkdata(8'h11));
        // the flush cycle itself held 11 against out_ready=0, so one more count; not cleared
        chk("fl_a_stall", a_stall,     16'd5);
        a_out_ready = 1'b1;
        tick();
        chk("fl_a_noemit", a_out_valid, 1'b0);
        chk("fl_a_stall_k", a_stall,    16'd5);

        // Stream on B (combinational ready)
        for (int i = 1; i <= 5; i++) begin
            b_in_valid = 1'b1; b_in_ctrl = 8'(16 + i); b_in_data = mkdata(8'(16 + i));
            tick();
            chk("strm_b_ctrl",  b_out_ctrl, 8'(16 + i));
            chk("strm_b_data",  b_out_data, mkdata(8'(16 + i)));
            chk("strm_b_ready", b_in_ready, 1'b1);
        end
        b_in_ctrl = 8'hA1; b_in_data = mkdata(8'hA1);
        tick();
        chk("bp_b_A1", b_out_ctrl, 8'hA1);
        b_out_ready = 1'b0; b_in_ctrl = 8'hB2; b_in_data = mkdata(8'hB2);
        #1;
        chk("bp_b_comb0", b_in_ready, 1'b0);
        b_out_ready = 1'b1;
        #1;
        chk("bp_b_comb1", b_in_ready, 1'b1);
        b_out_ready = 1'b0;
        tick();
        chk("bp_b_hold", b_out_ctrl, 8'hA1);
        chk("bp_b_stall", b_stall,   16'd1);
        b_out_ready = 1'b1;
        tick();
        chk("bp_b_B2", b_out_ctrl, 8'hB2);
        b_in_ctrl = 8'hC3; b_in_data = mkdata(8'hC3);
        tick();
        chk("bp_b_C3", b_out_ctrl, 8'hC3);
        b_in_valid = 1'b0;
        tick();
        chk("bp_b_empty", b_out_valid, 1'b0);
        chk("bp_b_ctrl0", b_out_ctrl,  8'h00);
        chk("bp_b_stall_k", b_stall,   16'd1);

        // Saturation on C: 4-bit counter held for 20 cycles
        c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_ctrl = 8'h5A; c_in_data = mkdata(8'h5A);
        tick();
        c_in_valid = 1'b0;
        chk("sat_c_start", c_stall, 4'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_c_14", c_stall, 4'hE);
            if (i == 15) chk("sat_c_15", c_stall, 4'hF);
        end
        chk("sat_c_20",    c_stall,    4'hF);
        chk("sat_c_ctrl",  c_out_ctrl, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
